// File: rtl/iq_select_multi.sv
// ---------------------------------------------------------------------------
// iq_select_multi
//
// Registered multi-grant issue-queue selector. Each non-stalled cycle it picks
// up to GNT_NUM requesting entries out of ENT_NUM, either lowest-index-first
// (ROTATE=0) or round-robin starting at ptr (ROTATE=1). Entries currently
// shown on the grant outputs are masked out of the next selection, because
// the issue queue only drops their request bit one cycle later.
//
// Parameters
//   ENT_NUM  number of issue-queue entries (must be 2**ENT_SEL)
//   ENT_SEL  entry index width
//   GNT_NUM  grants per cycle (1..ENT_NUM)
//   ROTATE   0 = fixed priority (entry 0 highest), 1 = rotating from ptr
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   request_i      per-entry ready/request vector
//   stall_i        downstream not ready: hold every register
//   flush_i        synchronous kill of displayed grants, resets ptr
//   grant_valid_o  bit k set = slot k carries a grant (packed from slot 0)
//   grant_idx_o    slot k entry index at [k*ENT_SEL +: ENT_SEL]
//   grant_vec_o    one-hot union of all valid grants
//   ptr_o          current highest-priority entry (0 when ROTATE=0)
// ---------------------------------------------------------------------------
module iq_select_multi #(
  parameter int ENT_NUM = 16,
  parameter int ENT_SEL = 4,
  parameter int GNT_NUM = 2,
  parameter int ROTATE  = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [ENT_NUM-1:0]         request_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [GNT_NUM-1:0]         grant_valid_o,
  output logic [GNT_NUM*ENT_SEL-1:0] grant_idx_o,
  output logic [ENT_NUM-1:0]         grant_vec_o,
  output logic [ENT_SEL-1:0]         ptr_o
);

  logic [GNT_NUM-1:0]         grant_valid_q, grant_valid_d;
  logic [GNT_NUM*ENT_SEL-1:0] grant_idx_q,   grant_idx_d;
  logic [ENT_NUM-1:0]         grant_vec_q,   grant_vec_d;
  logic [ENT_SEL-1:0]         ptr_q,         ptr_d;

  // First set bit of vec scanning start, start+1, ... with natural index wrap.
  // Result is {found, index}; index is 0 when nothing is found. The scan runs
  // from the far end downward so the nearest hit is the one that sticks.
  function automatic logic [ENT_SEL:0] find_first(
    input logic [ENT_NUM-1:0] vec,
    input logic [ENT_SEL-1:0] start
  );
    logic [ENT_SEL:0]   res;
    logic [ENT_SEL-1:0] pos;
    res = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      pos = start + ENT_SEL'(i);
      if (vec[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  // Grants being consumed this cycle must not be picked again while the
  // queue's request bit is still lagging.
  logic [ENT_NUM-1:0] eff;
  assign eff = request_i & ~grant_vec_q;

  // Slot chain: each slot takes the first remaining request in priority
  // order and removes it for the slots after it. This keeps indices distinct
  // and valid slots packed from slot 0 upward.
  logic [ENT_NUM-1:0] rem  [GNT_NUM+1];
  logic [ENT_SEL-1:0] last [GNT_NUM+1];
  logic [ENT_SEL:0]   hit  [GNT_NUM];

  logic [GNT_NUM-1:0]         sel_valid;
  logic [GNT_NUM*ENT_SEL-1:0] sel_idx;
  logic [ENT_NUM-1:0]         sel_vec;

  assign rem[0]  = eff;
  assign last[0] = '0;

  for (genvar gi = 0; gi < GNT_NUM; gi++) begin : g_slot
    assign hit[gi]       = find_first(rem[gi], ptr_q);
    assign sel_valid[gi] = hit[gi][ENT_SEL];
    assign sel_idx[gi*ENT_SEL +: ENT_SEL] = hit[gi][ENT_SEL-1:0];
    assign rem[gi+1]     = hit[gi][ENT_SEL]
                         ? (rem[gi] & ~(ENT_NUM'(1) << hit[gi][ENT_SEL-1:0]))
                         : rem[gi];
    // Index of the highest valid slot, used to advance the rotating pointer.
    assign last[gi+1]    = hit[gi][ENT_SEL] ? hit[gi][ENT_SEL-1:0] : last[gi];
  end

  // Everything that was removed along the chain is what got granted.
  assign sel_vec = eff & ~rem[GNT_NUM];

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    grant_vec_d   = grant_vec_q;
    ptr_d         = ptr_q;
    if (flush_i) begin
      grant_valid_d = '0;
      grant_idx_d   = '0;
      grant_vec_d   = '0;
      ptr_d         = '0;
    end else if (!stall_i) begin
      grant_valid_d = sel_valid;
      grant_idx_d   = sel_idx;
      grant_vec_d   = sel_vec;
      // Slot 0 valid means at least one grant. The wrap from ENT_NUM-1 to 0
      // falls out of the ENT_SEL-bit add.
      if ((ROTATE != 0) && sel_valid[0]) begin
        ptr_d = last[GNT_NUM] + ENT_SEL'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant_valid_q <= '0;
      grant_idx_q   <= '0;
      grant_vec_q   <= '0;
      ptr_q         <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      grant_vec_q   <= grant_vec_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_vec_o   = grant_vec_q;
  assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_iq_select_multi.sv
// ---------------------------------------------------------------------------
// tb_iq_select_multi
//
// Drives one fixed-priority and one rotating-priority selector (8 entries,
// 2 grants) with the same inputs and compares both against a behavioural
// model of the selection rules, plus directed expectations for the known
// scenarios (fixed pick, rotating sweep, wrap, stall hold, flush, async
// reset).
// ---------------------------------------------------------------------------
module tb_iq_select_multi;

  localparam int N  = 8;
  localparam int SW = 3;
  localparam int G  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] request;
  logic         stall;
  logic         flush;

  logic [G-1:0]    fx_valid, rt_valid;
  logic [G*SW-1:0] fx_idx,   rt_idx;
  logic [N-1:0]    fx_vec,   rt_vec;
  logic [SW-1:0]   fx_ptr,   rt_ptr;

  int checks   = 0;
  int failures = 0;

  // Model state, index 0 = fixed DUT, 1 = rotating DUT.
  int           m_cnt [2];
  int           m_idx [2][G];
  logic [N-1:0] m_vec [2];
  int           m_ptr [2];

  always #5 clk = ~clk;

  iq_select_multi #(.ENT_NUM(N), .ENT_SEL(SW), .GNT_NUM(G), .ROTATE(0)) u_fix (
    .clk_i(clk), .reset_i(reset), .request_i(request), .stall_i(stall), .flush_i(flush),
    .grant_valid_o(fx_valid), .grant_idx_o(fx_idx), .grant_vec_o(fx_vec), .ptr_o(fx_ptr)
  );

  iq_select_multi #(.ENT_NUM(N), .ENT_SEL(SW), .GNT_NUM(G), .ROTATE(1)) u_rot (
    .clk_i(clk), .reset_i(reset), .request_i(request), .stall_i(stall), .flush_i(flush),
    .grant_valid_o(rt_valid), .grant_idx_o(rt_idx), .grant_vec_o(rt_vec), .ptr_o(rt_ptr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      m_vec[m] = '0;
      m_ptr[m] = 0;
      for (int k = 0; k < G; k++) m_idx[m][k] = 0;
    end
  endtask

  // Walk entries in priority order from ptr and hand out up to G grants.
  task automatic model_edge(input logic [N-1:0] r, input logic s, input logic f);
    logic [N-1:0] eff;
    int p;
    for (int m = 0; m < 2; m++) begin
      if (f) begin
        m_cnt[m] = 0;
        m_vec[m] = '0;
        m_ptr[m] = 0;
        for (int k = 0; k < G; k++) m_idx[m][k] = 0;
      end else if (!s) begin
        eff = r & ~m_vec[m];
        m_cnt[m] = 0;
        m_vec[m] = '0;
        for (int k = 0; k < G; k++) m_idx[m][k] = 0;
        for (int i = 0; i < N; i++) begin
          p = (m_ptr[m] + i) % N;
          if (eff[p] && m_cnt[m] < G) begin
            m_idx[m][m_cnt[m]] = p;
            m_vec[m][p] = 1'b1;
            m_cnt[m]++;
          end
        end
        if (m == 1 && m_cnt[m] > 0) m_ptr[m] = (m_idx[m][m_cnt[m]-1] + 1) % N;
      end
    end
  endtask

  function automatic logic [31:0] exp_valid(input int m);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < G; k++) if (k < m_cnt[m]) v[k] = 1'b1;
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, " fix.valid"}, 32'(fx_valid),      exp_valid(0));
    check_eq({tag, " fix.idx0"},  32'(fx_idx[2:0]),   32'(m_idx[0][0]));
    check_eq({tag, " fix.idx1"},  32'(fx_idx[5:3]),   32'(m_idx[0][1]));
    check_eq({tag, " fix.vec"},   32'(fx_vec),        32'(m_vec[0]));
    check_eq({tag, " fix.ptr"},   32'(fx_ptr),        32'(m_ptr[0]));
    check_eq({tag, " rot.valid"}, 32'(rt_valid),      exp_valid(1));
    check_eq({tag, " rot.idx0"},  32'(rt_idx[2:0]),   32'(m_idx[1][0]));
    check_eq({tag, " rot.idx1"},  32'(rt_idx[5:3]),   32'(m_idx[1][1]));
    check_eq({tag, " rot.vec"},   32'(rt_vec),        32'(m_vec[1]));
    check_eq({tag, " rot.ptr"},   32'(rt_ptr),        32'(m_ptr[1]));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " fix.valid0"}, 32'(fx_valid), 32'd0);
    check_eq({tag, " fix.idx0"},   32'(fx_idx),   32'd0);
    check_eq({tag, " fix.vec0"},   32'(fx_vec),   32'd0);
    check_eq({tag, " rot.valid0"}, 32'(rt_valid), 32'd0);
    check_eq({tag, " rot.idx0"},   32'(rt_idx),   32'd0);
    check_eq({tag, " rot.vec0"},   32'(rt_vec),   32'd0);
    check_eq({tag, " rot.ptr0"},   32'(rt_ptr),   32'd0);
  endtask

  // Apply inputs, take one edge, then compare both DUTs with the model.
  task automatic step(input string tag, input logic [N-1:0] r, input logic s, input logic f);
    request = r;
    stall   = s;
    flush   = f;
    @(posedge clk);
    model_edge(r, s, f);
    #1;
    compare_all(tag);
    $display("txn %-8s req=%b stall=%0d flush=%0d rot: v=%b idx=%0d,%0d ptr=%0d",
             tag, r, s, f, rt_valid, rt_idx[2:0], rt_idx[5:3], rt_ptr);
  endtask

  initial begin
    reset   = 1'b1;
    request = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    model_reset();

    // Reset held across edges: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    reset = 1'b0;

    // Fixed-priority pick and mask on the second cycle.
    step("fixed1", 8'b1010_0110, 1'b0, 1'b0);
    check_eq("fixed1 valid", 32'(fx_valid), 32'h3);
    check_eq("fixed1 idx0",  32'(fx_idx[2:0]), 32'd1);
    check_eq("fixed1 idx1",  32'(fx_idx[5:3]), 32'd2);
    check_eq("fixed1 vec",   32'(fx_vec), 32'h06);
    step("fixed2", 8'b1010_0110, 1'b0, 1'b0);
    check_eq("fixed2 idx0",  32'(fx_idx[2:0]), 32'd5);
    check_eq("fixed2 idx1",  32'(fx_idx[5:3]), 32'd7);

    // Rotating sweep with all requests held.
    for (int i = 0; i < 5; i++) begin
      step("sweep", 8'hFF, 1'b0, 1'b0);
      check_eq("sweep idx0", 32'(rt_idx[2:0]), 32'((2 * i) % N));
      check_eq("sweep idx1", 32'(rt_idx[5:3]), 32'((2 * i + 1) % N));
      check_eq("sweep ptr",  32'(rt_ptr),      32'((2 * i + 2) % N));
    end

    // Walk the rotating pointer to 6, then wrap and a partial grant.
    step("to6a", 8'hFF, 1'b0, 1'b0);
    step("to6b", 8'hFF, 1'b0, 1'b0);
    check_eq("to6 ptr", 32'(rt_ptr), 32'd6);
    step("wrap", 8'b0100_0001, 1'b0, 1'b0);
    check_eq("wrap idx0", 32'(rt_idx[2:0]), 32'd6);
    check_eq("wrap idx1", 32'(rt_idx[5:3]), 32'd0);
    check_eq("wrap ptr",  32'(rt_ptr), 32'd1);
    step("partial", 8'b0000_0100, 1'b0, 1'b0);
    check_eq("partial valid", 32'(rt_valid), 32'h1);
    check_eq("partial idx0",  32'(rt_idx[2:0]), 32'd2);
    check_eq("partial idx1",  32'(rt_idx[5:3]), 32'd0);
    check_eq("partial ptr",   32'(rt_ptr), 32'd3);

    // Stall with grants displayed; request wanders meanwhile.
    step("prestall", 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 8'($urandom), 1'b1, 1'b0);
      check_eq("stall idx0", 32'(rt_idx[2:0]), 32'd3);
      check_eq("stall idx1", 32'(rt_idx[5:3]), 32'd4);
      check_eq("stall ptr",  32'(rt_ptr), 32'd5);
    end
    step("unstall", 8'hFF, 1'b0, 1'b0);
    check_eq("unstall mask", 32'(rt_vec & 8'h18), 32'd0);
    check_eq("unstall idx0", 32'(rt_idx[2:0]), 32'd5);

    // Flush beats stall.
    step("flush", 8'hFF, 1'b1, 1'b1);
    check_zero("flush");
    step("postflush", 8'h80, 1'b0, 1'b0);
    check_eq("postflush valid", 32'(rt_valid), 32'h1);
    check_eq("postflush idx0",  32'(rt_idx[2:0]), 32'd7);
    check_eq("postflush fvld",  32'(fx_valid), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges, while stalled with grants shown.
    step("prerst", 8'hFF, 1'b0, 1'b0);
    step("prerst2", 8'hFF, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_held");
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("after", 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iq_select_multi.md
# iq_select_multi

Parametrised, registered multi-grant issue-queue selector. Each cycle it picks up to GNT_NUM requesting entries from an ENT_NUM-entry issue queue, either lowest-index-first or rotating priority. Grants are registered with a downstream stall handshake. Entries already shown on the grant outputs are masked from the next selection, so a queue that clears its request one cycle late never double-issues. It sits between the issue-queue ready vector and the issue-port muxes.

## Interface
- ENT_NUM, 16, number of issue-queue entries; must equal 2**ENT_SEL
- ENT_SEL, 4, entry index width
- GNT_NUM, 2, grants per cycle (1..ENT_NUM)
- ROTATE, 1, 0 = fixed priority (index 0 highest), 1 = rotating priority from ptr
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- request  input  ENT_NUM  per-entry ready/request vector
- stall  input  1  downstream not ready; hold outputs
- flush  input  1  synchronous kill of in-flight grants
- grant_valid  output  GNT_NUM  bit k set = slot k carries a grant
- grant_idx  output  GNT_NUM*ENT_SEL  slot k index at bits [k*ENT_SEL +: ENT_SEL]
- grant_vec  output  ENT_NUM  one-hot union of all valid grants
- ptr  output  ENT_SEL  current highest-priority entry (always 0 when ROTATE=0)

## Operation
- All outputs and ptr are registers.
- Reset values: grant_valid=0, grant_idx=0, grant_vec=0, ptr=0.
- Effective request: eff = request & ~grant_vec.
  - grant_vec is the current registered value, i.e. grants being consumed this cycle.
- Priority order: ptr, ptr+1, …, ptr+ENT_NUM-1, all modulo ENT_NUM (natural wrap of ENT_SEL bits).
  - ROTATE=0: order is 0..ENT_NUM-1.
- Slot assignment: slot 0 gets the first set bit of eff in priority order, slot 1 the second, and so on up to GNT_NUM.
  - If eff has fewer than GNT_NUM bits set, the upper slots get valid=0 and idx=0.
  - Valid slots are always packed from slot 0 upward.
- Distinctness: granted indices within a cycle are distinct; grant_vec has exactly popcount(grant_valid) bits set.
- Update rule at each edge, highest priority first:
  1. flush=1: grant_valid, grant_idx, grant_vec ← 0; ptr ← 0. Flush overrides stall.
  2. stall=1: all registers hold; request is ignored.
  3. otherwise: outputs ← new selection from eff.
     - ROTATE=1 and at least one grant: ptr ← (index in the highest valid slot) + 1, mod ENT_NUM.
     - No grant, or ROTATE=0: ptr holds.
- eff=0 with stall=0: outputs go to all-zero; ptr holds.

## Timing
- Latency is one cycle: request sampled at edge t appears on the outputs after edge t.
- Handshake: a displayed grant is consumed at any edge where stall=0 and flush=0.
  - The queue clears the request bit at or after that edge.
  - The mask covers the one cycle in which the request bit is still set.
- A stall of any length holds outputs and ptr bit-exact.
  - The first non-stalled edge afterwards selects with the held grant_vec as the mask.
- Asynchronous reset clears every register immediately, mid-stall or mid-flush, without waiting for clk.
  - Operation resumes on the first edge after reset deasserts.
- Throughput: up to GNT_NUM grants per non-stalled cycle, with no bubble between consecutive selections.

## Test plan
1. Reset: assert reset asynchronously between edges → grant_valid=0, grant_vec=0, all grant_idx=0, ptr=0 immediately; they stay 0 through the edges while reset is held.
2. Fixed mode, ENT_NUM=8, GNT_NUM=2, ROTATE=0.
   - Stimulus: request=8'b1010_0110, held for two cycles.
   - Edge 1 → grant_valid=2'b11, idx0=1, idx1=2, grant_vec=8'b0000_0110.
   - Edge 2 (mask applied) → idx0=5, idx1=7.
3. Rotating sweep, ROTATE=1, request=8'hFF held, no stall.
   - Successive grant pairs are (0,1), (2,3), (4,5), (6,7), (0,1).
   - ptr goes 2, 4, 6, 0, 2.
4. Wrap and partial grant: ptr=6, request=8'b0100_0001 → idx0=6, idx1=0, ptr=1.
   - Then request=8'b0000_0100 (bit 2) → grant_valid=2'b01, idx0=2, idx1=0, ptr=3.
5. Stall: with valid grants displayed, assert stall for 3 cycles while request changes randomly.
   - Outputs and ptr remain unchanged for all 3 cycles.
   - On deassert, the next selection excludes the entries that were held in grant_vec.
6. Flush: assert flush together with stall while grants are valid.
   - Next edge → grant_valid=0, grant_vec=0, ptr=0.
   - Following edge with request=8'h80 → idx0=7, grant_valid=2'b01.
